// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO constants, read-mode encoding and clog2 helper
package fifo_pkg;

   localparam int FIFO_DATA_WIDTH_DEF = 8;
   localparam int FIFO_DEPTH_DEF      = 8;

   // FWFT parameter values, shared with the asynchronous FIFO
   localparam int FWFT_OFF = 0;
   localparam int FWFT_ON  = 1;

   typedef enum logic {
      RD_MODE_REG  = 1'b0,
      RD_MODE_FWFT = 1'b1
   } rd_mode_e;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/fifo_dp_ram.sv
// rtl/fifo_dp_ram.sv - register-file store, synchronous write, asynchronous read, no reset
module fifo_dp_ram #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 8,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// rtl/sync_fifo_ctrl.sv - single-clock FIFO: pointers, occupancy, flags, sticky errors, read mode
module sync_fifo_ctrl
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = FIFO_DATA_WIDTH_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
   parameter int ADDR_WIDTH = 3,
   parameter int AF_LEVEL   = 6,
   parameter int AE_LEVEL   = 2,
   parameter int FWFT       = FWFT_OFF
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  WR_EN,
   input  logic [DATA_WIDTH-1:0] WR_DATA,
   input  logic                  RD_EN,
   output logic [DATA_WIDTH-1:0] RD_DATA,
   output logic                  RD_VALID,
   output logic                  FULL,
   output logic                  EMPTY,
   output logic                  ALMOST_FULL,
   output logic                  ALMOST_EMPTY,
   output logic [ADDR_WIDTH:0]   COUNT,
   output logic                  OVERFLOW,
   output logic                  UNDERFLOW,
   input  logic                  CLR_ERR
);

   if (ADDR_WIDTH != clog2(FIFO_DEPTH)) begin : g_bad_addr_width
      $fatal(1, "sync_fifo_ctrl: ADDR_WIDTH must equal log2(FIFO_DEPTH)");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $fatal(1, "sync_fifo_ctrl: FIFO_DEPTH must be a power of two >= 2");
   end
   if (AF_LEVEL < 1 || AF_LEVEL > FIFO_DEPTH) begin : g_bad_af
      $fatal(1, "sync_fifo_ctrl: AF_LEVEL out of range");
   end
   if (AE_LEVEL < 0 || AE_LEVEL > FIFO_DEPTH - 1) begin : g_bad_ae
      $fatal(1, "sync_fifo_ctrl: AE_LEVEL out of range");
   end

   localparam rd_mode_e            RD_MODE = (FWFT != 0) ? RD_MODE_FWFT : RD_MODE_REG;
   localparam logic [ADDR_WIDTH:0] AF_THR  = (ADDR_WIDTH + 1)'(AF_LEVEL);
   localparam logic [ADDR_WIDTH:0] AE_THR  = (ADDR_WIDTH + 1)'(AE_LEVEL);
   localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

   logic [ADDR_WIDTH:0]   wr_ptr;
   logic [ADDR_WIDTH:0]   rd_ptr;
   logic [ADDR_WIDTH:0]   count;
   logic                  empty;
   logic                  full;
   logic                  wr_acc;
   logic                  rd_acc;
   logic                  overflow_q;
   logic                  underflow_q;
   logic [DATA_WIDTH-1:0] ram_rdata;

   // Extra MSB on each pointer is the wrap bit that separates full from empty
   assign count  = wr_ptr - rd_ptr;
   assign empty  = (wr_ptr == rd_ptr);
   assign full   = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                   (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
   assign wr_acc = WR_EN & ~full;
   assign rd_acc = RD_EN & ~empty;

   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (rd_acc) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         // A new error event outranks a clear in the same cycle
         overflow_q  <= (WR_EN & full)  | (overflow_q  & ~CLR_ERR);
         underflow_q <= (RD_EN & empty) | (underflow_q & ~CLR_ERR);
      end
   end

   fifo_dp_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk   (CLK),
      .we    (wr_acc),
      .waddr (wr_ptr[ADDR_WIDTH-1:0]),
      .wdata (WR_DATA),
      .raddr (rd_ptr[ADDR_WIDTH-1:0]),
      .rdata (ram_rdata)
   );

   if (RD_MODE == RD_MODE_FWFT) begin : g_fwft
      assign RD_DATA  = empty ? '0 : ram_rdata;
      assign RD_VALID = ~empty;
   end else begin : g_reg
      logic [DATA_WIDTH-1:0] rd_data_q;
      logic                  rd_valid_q;

      always_ff @(posedge CLK) begin
         if (RST) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
         end else begin
            rd_valid_q <= rd_acc;
            if (rd_acc) begin
               rd_data_q <= ram_rdata;
            end
         end
      end

      assign RD_DATA  = rd_data_q;
      assign RD_VALID = rd_valid_q;
   end

   assign FULL         = full;
   assign EMPTY        = empty;
   assign COUNT        = count;
   assign ALMOST_FULL  = (count >= AF_THR);
   assign ALMOST_EMPTY = (count <= AE_THR);
   assign OVERFLOW     = overflow_q;
   assign UNDERFLOW    = underflow_q;

endmodule
